// File: rtl/load_store_unit.sv
// Memory stage of an in-order pipeline: issues one load/store at a time over a req/ack
// memory port, extends load data, passes the instruction to writeback and raises sticky halts.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_mem,
    input  logic [31:0] Instr_in_mem,
    input  logic [31:0] PC_in_mem,
    input  logic [31:0] ALUOutput_in_mem,
    input  logic [31:0] Rdata2_in_mem,
    input  logic        halt_in_mem,
    output logic        stall_out_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        valid_out_mem,
    output logic [31:0] Instr_out_mem,
    output logic [31:0] PC_out_mem,
    output logic [31:0] ALUOutput_out_mem,
    output logic [31:0] MemData_out_mem,
    output logic        halt_out_mem,
    output logic [1:0]  state_dbg
);
    // Handshake: mem_req is raised with all request fields and they hold unchanged until the
    // cycle mem_ack is high; that cycle completes the access and mem_rdata is sampled.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HALTED = 2'd2} state_t;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] busy_instr;
    logic [31:0] busy_pc;
    logic [31:0] busy_alu;

    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic        is_load;
    logic        is_store;
    logic        f3_legal;
    logic        aligned;
    logic        issue;
    logic        idle_halt;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign state_dbg = state;

    always_comb begin
        funct3   = Instr_in_mem[14:12];
        lane     = ALUOutput_in_mem[1:0];
        is_load  = (Instr_in_mem[6:0] == OP_LOAD);
        is_store = (Instr_in_mem[6:0] == OP_STORE);
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
        // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word
        case (funct3[1:0])
            2'b00: begin
                aligned    = 1'b1;
                strb_next  = 4'b0001 << lane;
                wdata_next = {4{Rdata2_in_mem[7:0]}};
            end
            2'b01: begin
                aligned    = ~lane[0];
                strb_next  = 4'b0011 << lane;
                wdata_next = {2{Rdata2_in_mem[15:0]}};
            end
            default: begin
                aligned    = (lane == 2'b00);
                strb_next  = 4'b1111;
                wdata_next = Rdata2_in_mem;
            end
        endcase
        issue     = (state == IDLE) && valid_in_mem && (is_load || is_store)
                    && f3_legal && aligned && !halt_in_mem;
        idle_halt = (state == IDLE) && (halt_in_mem ||
                    (valid_in_mem && (is_load || is_store) && !(f3_legal && aligned)));
        stall_out_mem = issue || ((state == BUSY) && !mem_ack);
    end

    always_comb begin
        shifted = mem_rdata >> {busy_alu[1:0], 3'b000};
        case (busy_instr[14:12])
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            wait_cnt          <= 8'd0;
            busy_instr        <= 32'd0;
            busy_pc           <= 32'd0;
            busy_alu          <= 32'd0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= 32'd0;
            mem_wdata         <= 32'd0;
            mem_wstrb         <= 4'd0;
            valid_out_mem     <= 1'b0;
            Instr_out_mem     <= 32'd0;
            PC_out_mem        <= 32'd0;
            ALUOutput_out_mem <= 32'd0;
            MemData_out_mem   <= 32'd0;
            halt_out_mem      <= 1'b0;
        end else begin
            valid_out_mem <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_halt) begin
                        halt_out_mem      <= 1'b1;
                        valid_out_mem     <= 1'b1;
                        Instr_out_mem     <= Instr_in_mem;
                        PC_out_mem        <= PC_in_mem;
                        ALUOutput_out_mem <= ALUOutput_in_mem;
                        state             <= HALTED;
                    end else if (issue) begin
                        mem_req    <= 1'b1;
                        mem_we     <= is_store;
                        mem_addr   <= {ALUOutput_in_mem[31:2], 2'b00};
                        mem_wdata  <= is_store ? wdata_next : 32'd0;
                        mem_wstrb  <= is_store ? strb_next : 4'd0;
                        wait_cnt   <= 8'd0;
                        busy_instr <= Instr_in_mem;
                        busy_pc    <= PC_in_mem;
                        busy_alu   <= ALUOutput_in_mem;
                        state      <= BUSY;
                    end else if (valid_in_mem) begin
                        valid_out_mem     <= 1'b1;
                        Instr_out_mem     <= Instr_in_mem;
                        PC_out_mem        <= PC_in_mem;
                        ALUOutput_out_mem <= ALUOutput_in_mem;
                    end
                end
                BUSY: begin
                    // Ack takes priority over an expiring wait counter.
                    if (mem_ack) begin
                        mem_req           <= 1'b0;
                        valid_out_mem     <= 1'b1;
                        Instr_out_mem     <= busy_instr;
                        PC_out_mem        <= busy_pc;
                        ALUOutput_out_mem <= busy_alu;
                        if (!mem_we) MemData_out_mem <= load_data;
                        state             <= IDLE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        mem_req           <= 1'b0;
                        halt_out_mem      <= 1'b1;
                        valid_out_mem     <= 1'b1;
                        Instr_out_mem     <= busy_instr;
                        PC_out_mem        <= busy_pc;
                        ALUOutput_out_mem <= busy_alu;
                        state             <= HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
